fifo_wr_arbiter: RTL and testbench

- Round-robin write-side scheduler that shares one asynchronous FIFO write port among NUM_REQ requesters.
- Grants the port to one requester per burst and forwards its beats to the FIFO write interface.
- Stalls on FIFO full.
- Bounds each burst to MAX_BURST beats so no requester can starve others.
- Lives entirely in the FIFO write clock domain, directly in front of the FIFO wr_en/d_in/full ports.

---
 rtl/fifo_wr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write-side scheduler that shares one FIFO write port among
// NUM_REQ requesters. A requester is granted the port for one burst. The burst
// ends on its last beat, or after MAX_BURST beats so that no requester can
// starve the others. Each arbitration costs one idle bubble cycle. Writes stall
// while the FIFO reports full. The block runs entirely in the FIFO write clock
// domain.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   DATA_W     beat width, equal to the FIFO data width
//   MAX_BURST  maximum beats per grant before forced rotation (1..255)
//
// Ports
//   i_wr_clk       FIFO write clock; all state changes on the rising edge
//   i_rst          asynchronous, active-high reset
//   i_req_valid    per-requester beat valid
//   i_req_last     per-requester end-of-packet flag, qualified by i_req_valid
//   i_req_data     packed beat data; requester i is [i*DATA_W +: DATA_W]
//   o_req_ack      one-hot: beat accepted this cycle
//   o_gnt          one-hot current owner (registered)
//   o_busy         high while a burst is granted (registered)
//   i_fifo_full    FIFO full flag
//   o_fifo_wr_en   FIFO write enable, always gated by ~i_fifo_full
//   o_fifo_d_in    FIFO write data (owner's slice, zero when no owner)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      i_wr_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_busy,
    input  logic                      i_fifo_full,
    output logic                      o_fifo_wr_en,
    output logic [DATA_W-1:0]         o_fifo_d_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    // Counter value of the final beat a single grant may carry.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [PTR_W-1:0]   r_own_idx;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_busy;

    logic               w_own_valid;
    logic               w_own_last;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_beat;
    logic               w_burst_end;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_next_ptr;

    // First requester with valid set, searching upward from ptr and wrapping.
    // The loop runs from the farthest candidate down to ptr itself, so the
    // nearest valid candidate is the last one written and wins.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            pick = valid[idx] ? PTR_W'(idx) : pick;
        end
        return pick;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // AND-OR mux of the owner's request fields. All zero when no grant is held,
    // which also forces the write data to zero outside a burst.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_own_valid = w_own_valid | (r_gnt[i] & i_req_valid[i]);
            w_own_last  = w_own_last  | (r_gnt[i] & i_req_last[i]);
            w_own_data  = w_own_data  | ({DATA_W{r_gnt[i]}} & i_req_data[i*DATA_W +: DATA_W]);
        end
    end

    // A beat moves only while a grant is held, the owner is valid and the FIFO
    // has room. The grant is nonzero only in XFER, so no separate state term.
    assign w_beat      = w_own_valid & ~i_fifo_full;
    assign w_burst_end = w_beat & (w_own_last | (r_beat_cnt == CNT_LAST));
    assign w_win_idx   = rr_pick(i_req_valid, r_rr_ptr);
    assign w_next_ptr  = (r_own_idx == PTR_TOP) ? {PTR_W{1'b0}} : (r_own_idx + PTR_W'(1));

    assign o_req_ack    = r_gnt & {NUM_REQ{w_beat}};
    assign o_fifo_wr_en = w_beat;
    assign o_fifo_d_in  = w_own_data;
    assign o_gnt        = r_gnt;
    assign o_busy       = r_busy;

    // Arbitration / burst FSM with registered grant, pointer, counter and busy.
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= {NUM_REQ{1'b0}};
            r_own_idx  <= {PTR_W{1'b0}};
            r_rr_ptr   <= {PTR_W{1'b0}};
            r_beat_cnt <= {CNT_W{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_req_valid) begin
                        r_gnt      <= to_onehot(w_win_idx);
                        r_own_idx  <= w_win_idx;
                        r_beat_cnt <= {CNT_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_state    <= ST_XFER;
                    end else begin
                        r_gnt      <= {NUM_REQ{1'b0}};
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (w_burst_end) begin
                        // Owner drops to lowest priority for the next round.
                        r_gnt      <= {NUM_REQ{1'b0}};
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end else begin
                        // FIFO full or owner not valid: hold the grant and count.
                        r_beat_cnt <= r_beat_cnt;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_gnt      <= {NUM_REQ{1'b0}};
                    r_beat_cnt <= {CNT_W{1'b0}};
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=8).
// Requesters are modelled as per-requester beat queues. A requester presents
// its queue head while enabled and pops it when the beat is acknowledged.
// Every FIFO write is logged with its owner and cycle number. Directed tasks
// compare outputs and the write log against hand-derived values. The random
// task compares every cycle against a behavioural model of the scheduling
// rules.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;
    localparam int QD        = 256;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        tb_valid;
    logic [NUM_REQ-1:0]        tb_last;
    logic [DATA_W-1:0]         tb_data [NUM_REQ];
    logic [NUM_REQ*DATA_W-1:0] req_data_p;
    logic                      tb_full;
    logic [NUM_REQ-1:0]        o_req_ack;
    logic [NUM_REQ-1:0]        o_gnt;
    logic                      o_busy;
    logic                      o_fifo_wr_en;
    logic [DATA_W-1:0]         o_fifo_d_in;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_data_p[gi*DATA_W +: DATA_W] = tb_data[gi];
    end

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_wr_clk     (clk),
        .i_rst        (rst),
        .i_req_valid  (tb_valid),
        .i_req_last   (tb_last),
        .i_req_data   (req_data_p),
        .o_req_ack    (o_req_ack),
        .o_gnt        (o_gnt),
        .o_busy       (o_busy),
        .i_fifo_full  (tb_full),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_d_in  (o_fifo_d_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int own;
        int data;
        int cyc;
    } wr_t;

    logic [8:0]         rq_mem [NUM_REQ][QD];
    int                 rq_head [NUM_REQ];
    int                 rq_tail [NUM_REQ];
    logic [NUM_REQ-1:0] en_mask;
    logic               full_next;
    int                 cyc;
    wr_t                wr_log [$];
    int                 n_checks;
    int                 n_pass;

    task automatic push_beat(input int r, input logic [7:0] d, input logic l);
        rq_mem[r][rq_tail[r] % QD] = {l, d};
        rq_tail[r]++;
    endtask

    // Called at a negedge: log this cycle's write, advance one clock, pop acked
    // beats, drive the next inputs, and return at the following negedge.
    task automatic cycle();
        logic [NUM_REQ-1:0] ack_s;
        wr_t e;
        if (o_fifo_wr_en === 1'b1) begin
            e.own = -1;
            for (int i = 0; i < NUM_REQ; i++) if (o_req_ack[i] === 1'b1) e.own = i;
            e.data = int'(o_fifo_d_in);
            e.cyc  = cyc;
            wr_log.push_back(e);
        end
        ack_s = o_req_ack;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_s[i] === 1'b1 && rq_head[i] != rq_tail[i]) rq_head[i]++;
            if (en_mask[i] && rq_head[i] != rq_tail[i]) begin
                tb_valid[i] = 1'b1;
                {tb_last[i], tb_data[i]} = rq_mem[i][rq_head[i] % QD];
            end else begin
                tb_valid[i] = 1'b0;
                tb_last[i]  = 1'($urandom);
                tb_data[i]  = 8'($urandom);
            end
        end
        tb_full = full_next;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
            tb_data[i] = 8'h00;
        end
        tb_valid  = 4'b0000;
        tb_last   = 4'b0000;
        tb_full   = 1'b0;
        full_next = 1'b0;
        en_mask   = 4'b1111;
        wr_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tb_valid = 4'b1111;
        tb_last  = 4'b1111;
        tb_full  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) tb_data[i] = 8'hA5;
        @(negedge clk);
        n_checks++; if (o_gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", o_gnt); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else n_pass++;
        n_checks++; if (o_req_ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", o_req_ack); else n_pass++;
        n_checks++; if (o_fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", o_fifo_wr_en); else n_pass++;
        n_checks++; if (o_fifo_d_in !== 8'h00) $display("FAIL reset_d_in got=%h exp=00", o_fifo_d_in); else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        push_beat(1, 8'hA1, 1'b0);
        push_beat(1, 8'hA2, 1'b0);
        push_beat(1, 8'hA3, 1'b1);
        cycle();
        n_checks++; if (o_gnt !== 4'b0000) $display("FAIL single_bubble_gnt got=%b exp=0000", o_gnt); else n_pass++;
        n_checks++; if (o_fifo_wr_en !== 1'b0) $display("FAIL single_bubble_wr got=%b exp=0", o_fifo_wr_en); else n_pass++;
        cycle();
        n_checks++; if (o_gnt !== 4'b0010) $display("FAIL single_gnt got=%b exp=0010", o_gnt); else n_pass++;
        n_checks++; if (o_busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", o_busy); else n_pass++;
        n_checks++; if (o_fifo_wr_en !== 1'b1) $display("FAIL single_wr0 got=%b exp=1", o_fifo_wr_en); else n_pass++;
        n_checks++; if (o_fifo_d_in !== 8'hA1) $display("FAIL single_d0 got=%h exp=a1", o_fifo_d_in); else n_pass++;
        n_checks++; if (o_req_ack !== 4'b0010) $display("FAIL single_ack0 got=%b exp=0010", o_req_ack); else n_pass++;
        cycle();
        n_checks++; if (o_fifo_wr_en !== 1'b1) $display("FAIL single_wr1 got=%b exp=1", o_fifo_wr_en); else n_pass++;
        n_checks++; if (o_fifo_d_in !== 8'hA2) $display("FAIL single_d1 got=%h exp=a2", o_fifo_d_in); else n_pass++;
        cycle();
        n_checks++; if (o_fifo_d_in !== 8'hA3) $display("FAIL single_d2 got=%h exp=a3", o_fifo_d_in); else n_pass++;
        n_checks++; if (o_req_ack !== 4'b0010) $display("FAIL single_ack2 got=%b exp=0010", o_req_ack); else n_pass++;
        cycle();
        n_checks++; if (o_gnt !== 4'b0000) $display("FAIL single_release got=%b exp=0000", o_gnt); else n_pass++;
        n_checks++; if (o_fifo_wr_en !== 1'b0) $display("FAIL single_idle_wr got=%b exp=0", o_fifo_wr_en); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", o_busy); else n_pass++;
        n_checks++; if (wr_log.size() != 3) $display("FAIL single_count got=%0d exp=3", wr_log.size()); else n_pass++;
        // Pointer now 2: with requesters 0,1,2 valid, requester 2 must win.
        push_beat(0, 8'h10, 1'b1);
        push_beat(1, 8'h11, 1'b1);
        push_beat(2, 8'h12, 1'b1);
        cycle();
        cycle();
        n_checks++; if (o_gnt !== 4'b0100) $display("FAIL single_rr_ptr got=%b exp=0100", o_gnt); else n_pass++;
        n_checks++; if (o_fifo_d_in !== 8'h12) $display("FAIL single_rr_data got=%h exp=12", o_fifo_d_in); else n_pass++;
    endtask

    task automatic test_round_robin();
        int cnt0;
        int cnt2;
        int exp_own;
        int exp_dat;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_beat(0, 8'(k), 1'b1);
            push_beat(2, 8'(8'h80 + k), 1'b1);
        end
        for (int c = 0; c < 100 && wr_log.size() < 20; c++) cycle();
        n_checks++; if (wr_log.size() != 20) $display("FAIL rr_count got=%0d exp=20", wr_log.size()); else n_pass++;
        cnt0 = 0;
        cnt2 = 0;
        for (int k = 0; k < wr_log.size(); k++) begin
            exp_own = (k % 2 == 0) ? 0 : 2;
            exp_dat = (k % 2 == 0) ? (k / 2) : (128 + k / 2);
            if (wr_log[k].own == 0) cnt0++;
            if (wr_log[k].own == 2) cnt2++;
            n_checks++; if (wr_log[k].own != exp_own) $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, wr_log[k].own, exp_own); else n_pass++;
            n_checks++; if (wr_log[k].data != exp_dat) $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, wr_log[k].data, exp_dat); else n_pass++;
            if (k > 0) begin
                n_checks++; if (wr_log[k].cyc - wr_log[k-1].cyc != 2) $display("FAIL rr_bubble[%0d] got=%0d exp=2", k, wr_log[k].cyc - wr_log[k-1].cyc); else n_pass++;
            end
        end
        n_checks++; if (cnt0 != 10 || cnt2 != 10) $display("FAIL rr_fair got=%0d/%0d exp=10/10", cnt0, cnt2); else n_pass++;
    endtask

    task automatic test_burst_cap();
        int exp_own [13];
        int exp_dat [13];
        do_reset();
        for (int k = 0; k < 12; k++) push_beat(3, 8'(8'h30 + k), (k == 11));
        en_mask = 4'b1000;
        cycle();
        en_mask = 4'b1111;
        push_beat(0, 8'h05, 1'b1);
        for (int c = 0; c < 80 && wr_log.size() < 13; c++) cycle();
        for (int k = 0; k < 8; k++) begin
            exp_own[k] = 3;
            exp_dat[k] = 8'h30 + k;
        end
        exp_own[8] = 0;
        exp_dat[8] = 8'h05;
        for (int k = 9; k < 13; k++) begin
            exp_own[k] = 3;
            exp_dat[k] = 8'h30 + k - 1;
        end
        n_checks++; if (wr_log.size() != 13) $display("FAIL cap_count got=%0d exp=13", wr_log.size()); else n_pass++;
        for (int k = 0; k < 13 && k < wr_log.size(); k++) begin
            n_checks++; if (wr_log[k].own != exp_own[k] || wr_log[k].data != exp_dat[k])
                $display("FAIL cap_beat[%0d] got=%0d:%0h exp=%0d:%0h", k, wr_log[k].own, wr_log[k].data, exp_own[k], exp_dat[k]); else n_pass++;
        end
        if (wr_log.size() >= 9) begin
            n_checks++; if (wr_log[7].cyc - wr_log[0].cyc != 7) $display("FAIL cap_contig got=%0d exp=7", wr_log[7].cyc - wr_log[0].cyc); else n_pass++;
            n_checks++; if (wr_log[8].cyc - wr_log[7].cyc != 2) $display("FAIL cap_rotate got=%0d exp=2", wr_log[8].cyc - wr_log[7].cyc); else n_pass++;
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int k = 0; k < 4; k++) push_beat(1, 8'(8'hB0 + k), (k == 3));
        cycle();
        cycle();
        cycle();
        full_next = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cycle();
            n_checks++; if (o_fifo_wr_en !== 1'b0) $display("FAIL stall_wr[%0d] got=%b exp=0", s, o_fifo_wr_en); else n_pass++;
            n_checks++; if (o_req_ack !== 4'b0000) $display("FAIL stall_ack[%0d] got=%b exp=0000", s, o_req_ack); else n_pass++;
            n_checks++; if (o_gnt !== 4'b0010 || o_fifo_d_in !== 8'hB2) $display("FAIL stall_hold[%0d] got=%b:%h exp=0010:b2", s, o_gnt, o_fifo_d_in); else n_pass++;
        end
        full_next = 1'b0;
        for (int c = 0; c < 20 && wr_log.size() < 4; c++) cycle();
        repeat (3) cycle();
        n_checks++; if (wr_log.size() != 4) $display("FAIL stall_count got=%0d exp=4", wr_log.size()); else n_pass++;
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            n_checks++; if (wr_log[k].data != 8'hB0 + k) $display("FAIL stall_data[%0d] got=%0h exp=%0h", k, wr_log[k].data, 8'hB0 + k); else n_pass++;
        end
    endtask

    task automatic test_valid_gap();
        do_reset();
        for (int k = 0; k < 4; k++) push_beat(2, 8'(8'hC0 + k), (k == 3));
        push_beat(0, 8'h0C, 1'b1);
        en_mask = 4'b0100;
        cycle();
        cycle();
        en_mask = 4'b1111;
        cycle();
        en_mask = 4'b1011;
        for (int s = 0; s < 3; s++) begin
            cycle();
            n_checks++; if (o_gnt !== 4'b0100) $display("FAIL gap_gnt[%0d] got=%b exp=0100", s, o_gnt); else n_pass++;
            n_checks++; if (o_req_ack !== 4'b0000 || o_fifo_wr_en !== 1'b0) $display("FAIL gap_ack[%0d] got=%b:%b exp=0000:0", s, o_req_ack, o_fifo_wr_en); else n_pass++;
        end
        en_mask = 4'b1111;
        for (int c = 0; c < 30 && wr_log.size() < 5; c++) cycle();
        n_checks++; if (wr_log.size() != 5) $display("FAIL gap_count got=%0d exp=5", wr_log.size()); else n_pass++;
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            n_checks++; if (wr_log[k].own != 2 || wr_log[k].data != 8'hC0 + k) $display("FAIL gap_owner[%0d] got=%0d:%0h exp=2:%0h", k, wr_log[k].own, wr_log[k].data, 8'hC0 + k); else n_pass++;
        end
        if (wr_log.size() >= 5) begin
            n_checks++; if (wr_log[4].own != 0 || wr_log[4].data != 8'h0C) $display("FAIL gap_other got=%0d:%0h exp=0:c", wr_log[4].own, wr_log[4].data); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // Finish one burst from requester 2 so the pointer moves to 3.
        push_beat(2, 8'hE0, 1'b1);
        en_mask = 4'b0100;
        cycle();
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) push_beat(1, 8'(8'hD0 + k), (k == 3));
        en_mask = 4'b0010;
        cycle();
        cycle();
        cycle();
        n_checks++; if (o_fifo_wr_en !== 1'b1 || o_fifo_d_in !== 8'hD1) $display("FAIL rstmid_pre got=%b:%h exp=1:d1", o_fifo_wr_en, o_fifo_d_in); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (o_gnt !== 4'b0000) $display("FAIL rstmid_gnt got=%b exp=0000", o_gnt); else n_pass++;
        n_checks++; if (o_fifo_wr_en !== 1'b0) $display("FAIL rstmid_wr got=%b exp=0", o_fifo_wr_en); else n_pass++;
        n_checks++; if (o_req_ack !== 4'b0000 || o_busy !== 1'b0) $display("FAIL rstmid_ack got=%b:%b exp=0000:0", o_req_ack, o_busy); else n_pass++;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) push_beat(i, 8'(8'hF0 + i), 1'b1);
        cycle();
        cycle();
        n_checks++; if (o_gnt !== 4'b0001) $display("FAIL rstmid_restart got=%b exp=0001", o_gnt); else n_pass++;
        n_checks++; if (o_fifo_d_in !== 8'hF0) $display("FAIL rstmid_data got=%h exp=f0", o_fifo_d_in); else n_pass++;
    endtask

    task automatic test_random();
        int                 m_owner;
        int                 m_ptr;
        int                 m_sent;
        int                 len;
        int                 idx;
        logic               exp_beat;
        logic [NUM_REQ-1:0] one;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] exp_ack;
        logic [DATA_W-1:0]  exp_data;
        do_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sent  = 0;
        one     = 4'b0001;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq_head[i] == rq_tail[i] && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 12);
                    for (int b = 0; b < len; b++) push_beat(i, 8'($urandom), (b == len - 1));
                end
                en_mask[i] = ($urandom_range(0, 99) < 85);
            end
            full_next = ($urandom_range(0, 99) < 25);
            cycle();
            exp_gnt  = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
            exp_beat = (m_owner >= 0) ? (tb_valid[m_owner] & ~tb_full) : 1'b0;
            exp_ack  = exp_beat ? exp_gnt : 4'b0000;
            exp_data = (m_owner >= 0) ? tb_data[m_owner] : 8'h00;
            n_checks++; if (o_gnt !== exp_gnt) $display("FAIL rand_gnt@%0d got=%b exp=%b", c, o_gnt, exp_gnt); else n_pass++;
            n_checks++; if (o_fifo_wr_en !== exp_beat) $display("FAIL rand_wr@%0d got=%b exp=%b", c, o_fifo_wr_en, exp_beat); else n_pass++;
            n_checks++; if (o_req_ack !== exp_ack) $display("FAIL rand_ack@%0d got=%b exp=%b", c, o_req_ack, exp_ack); else n_pass++;
            n_checks++; if (o_fifo_d_in !== exp_data) $display("FAIL rand_data@%0d got=%h exp=%h", c, o_fifo_d_in, exp_data); else n_pass++;
            n_checks++; if (o_busy !== (m_owner >= 0)) $display("FAIL rand_busy@%0d got=%b exp=%b", c, o_busy, (m_owner >= 0)); else n_pass++;
            // Reference scheduler: whoever is first at or after the pointer
            // wins; a burst ends on last or after MAX_BURST beats.
            if (m_owner < 0) begin
                if (|tb_valid) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        idx = (m_ptr + k) % NUM_REQ;
                        if (tb_valid[idx]) begin
                            m_owner = idx;
                            break;
                        end
                    end
                    m_sent = 0;
                end
            end else if (exp_beat) begin
                m_sent++;
                if (tb_last[m_owner] || m_sent == MAX_BURST) begin
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        en_mask  = 4'b1111;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_full_stall();
        test_valid_gap();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
